jtag_ahb_dap: RTL and testbench
===============================

# jtag_ahb_dap

Parametrised JTAG debug access port: a full IEEE 1149.1 TAP controller with a configurable instruction register, driving a single-master AHB-Lite interface. It extends the existing single-transfer JTAG-to-AHB bridge with four additions: parametrised data and address widths, a control/status register (CSR), address auto-increment, and sticky error and overrun reporting. It sits between the external debug pins and the system AHB-Lite fabric, and everything runs on TCK.

## Interface
- REGISTER_SIZE, 32, data register and AHB data width (32 or 64).
- ADDR_SIZE, 32, HADDR width.
- IR_SIZE, 4, instruction register width (at least 4).
- STATE_SIZE, 4, TAP state encoding width.
- IDCODE_VALUE, 32'h1000_0A5B, value captured by IDCODE (bit 0 must be 1).
- TCK  in  1  sole clock; TAP and AHB logic run on posedge, TDO on negedge.
- TRST_N  in  1  asynchronous, active-low reset.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in, LSB first.
- TDO  out  1  serial data out.
- HREADY  in  1  AHB transfer done.
- HRESP  in  1  AHB error response.
- HRDATA  in  REGISTER_SIZE  AHB read data.
- HADDR  out  ADDR_SIZE  AHB address.
- HWRITE  out  1  AHB direction.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HSIZE  out  3  from CSR.
- HWDATA  out  REGISTER_SIZE  AHB write data.

## Operation
- TAP: the standard 16-state FSM (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents). Five TCK with TMS=1 reach TLR from any state. TLR loads IR with IDCODE.
- Instructions (IR_SIZE=4): BYPASS 4'h0, IDCODE 4'h8, ADDR 4'h4, WDATA 4'hC, RDATA 4'h2, CSR 4'hA. Any other code behaves as BYPASS.
- Capture-IR loads 4'b0001 (LSB first) into the IR shifter. IR updates on Update-IR.
- DR selection:
  - BYPASS: 1 bit, captures 0.
  - IDCODE: 32 bits, captures IDCODE_VALUE; update has no effect.
  - ADDR: ADDR_SIZE bits, captures the current address; Update-DR loads the address.
  - WDATA: REGISTER_SIZE bits. Update-DR loads the write data and launches an AHB write.
  - RDATA: REGISTER_SIZE bits, captures the last read data. Update-DR launches an AHB read; the shifted-in value is discarded.
  - CSR: 8 bits.
    - [0] autoinc, read/write.
    - [3:1] hsize, read/write, reset 3'b010.
    - [4] err, sticky, write-1-to-clear.
    - [5] ovr, sticky, write-1-to-clear.
    - [6] busy, read-only.
    - [7] reserved, reads 0.
- AHB master FSM:
  - IDLE -> ADDR on a launch.
  - ADDR -> DATA after exactly one TCK.
  - DATA -> IDLE when HREADY=1.
- On completion:
  - A read latches HRDATA into the read-data register.
  - HRESP=1 sets CSR.err.
  - If autoinc=1, the address increases by 1<<hsize, with modulo-2^ADDR_SIZE wrap.
- A launch while busy is dropped and sets CSR.ovr; the address, write data and bus are unaffected.
- Simultaneous completion and a W1C on err (or ovr): the set wins.

## Timing
- Reset values:
  - TDO=0, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=3'b010.
  - TAP in TLR, IR=IDCODE, CSR=8'h04, read-data register 0.
- Reset is asynchronous. Asserting TRST_N mid-transfer returns both FSMs to their reset state immediately and drives HTRANS=IDLE; the in-flight result is lost.
- TDI is sampled on posedge while in ShDR/ShIR. TDO updates on negedge from the shifter LSB, and is 0 outside the shift states.
- Launch happens on the posedge at which the TAP leaves UpdDR:
  - HTRANS=NONSEQ, HADDR and HWRITE are valid for that one cycle.
  - HWDATA is valid from the next posedge until completion.
  - HTRANS returns to IDLE in the data phase.
- Minimum latency is 2 TCK from the UpdDR exit to completion, plus one TCK per HREADY=0 cycle. busy is high from launch until the completion edge.
- The auto-increment address is visible on the posedge after completion.

## Structure
- Package jtag_ahb_dap_pkg holds:
  - TAP state enum.
  - Instruction code constants.
  - CSR bit index constants.
  - AHB HTRANS/HSIZE constants.
- Sub-module jtag_tap_fsm: the TAP state machine only. Inputs TCK, TRST_N, TMS; output is the state. The DR/IR shifters and the AHB master stay in the top level.

## Test plan
- Reset: pulse TRST_N, then RTI and read DR -> 32 bits out equal IDCODE_VALUE. Five TMS=1 from ShDR -> TLR, IR=4'h8.
- BYPASS and an unknown IR code 4'hF: shift 8'hA5 -> TDO returns 8'hA5 delayed by one bit.
- Write with auto-increment:
  - Setup: CSR=8'h05, ADDR=32'h100.
  - Stimulus: WDATA 32'h89ABCDEF, then 32'h1.
  - Required: two NONSEQ writes at 0x100 and 0x104 with matching HWDATA; final address 0x108.
- Read:
  - Setup: HRDATA=32'hF00F, HREADY held low for 3 cycles.
  - Stimulus: RDATA update; busy seen in CSR during the wait.
  - Required: completion 5 TCK after the UpdDR exit; a following RDATA capture shifts out 32'hF00F.
- Error and overrun:
  - HRESP=1 -> CSR.err=1. A second launch during HREADY=0 -> ovr=1 and no second NONSEQ.
  - Writing CSR 8'h34 (W1C on err and ovr, hsize kept) clears both.
- Reset mid-transfer: TRST_N low during the data phase -> HTRANS=00 and CSR=8'h04 immediately, without waiting for a TCK edge.

Source files
------------

// File: rtl/jtag_ahb_dap_pkg.sv
// Shared types and constants for the JTAG-to-AHB debug access port.
package jtag_ahb_dap_pkg;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {AHB_IDLE, AHB_ADDR, AHB_DATA} ahb_state_t;

  typedef enum logic [2:0] {
    DR_BYPASS, DR_IDCODE, DR_ADDR, DR_WDATA, DR_RDATA, DR_CSR
  } dr_sel_t;

  localparam logic [3:0] IR_BYPASS = 4'h0;
  localparam logic [3:0] IR_IDCODE = 4'h8;
  localparam logic [3:0] IR_ADDR   = 4'h4;
  localparam logic [3:0] IR_WDATA  = 4'hC;
  localparam logic [3:0] IR_RDATA  = 4'h2;
  localparam logic [3:0] IR_CSR    = 4'hA;

  localparam int CSR_AUTOINC  = 0;
  localparam int CSR_HSIZE_LO = 1;
  localparam int CSR_HSIZE_HI = 3;
  localparam int CSR_ERR      = 4;
  localparam int CSR_OVR      = 5;
  localparam int CSR_BUSY     = 6;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/jtag_ahb_dap_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
module jtag_tap_fsm import jtag_ahb_dap_pkg::*; #(
  parameter int STATE_SIZE = 4
) (
  input  logic                  TCK,
  input  logic                  TRST_N,
  input  logic                  TMS,
  output logic [STATE_SIZE-1:0] o_state
);

  tap_state_t r_state;
  tap_state_t w_next;

  // TAP state register, TLR on reset
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) r_state <= TLR;
    else         r_state <= w_next;
  end

  // Standard TMS-driven next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = TMS ? TLR      : RTI;
      RTI:      w_next = TMS ? SEL_DR   : RTI;
      SEL_DR:   w_next = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next = TMS ? EX1_DR   : SH_DR;
      SH_DR:    w_next = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   w_next = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   w_next = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   w_next = TMS ? SEL_DR   : RTI;
      SEL_IR:   w_next = TMS ? TLR      : CAP_IR;
      CAP_IR:   w_next = TMS ? EX1_IR   : SH_IR;
      SH_IR:    w_next = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   w_next = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   w_next = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   w_next = TMS ? SEL_DR   : RTI;
      default:  w_next = TLR;
    endcase
  end

  assign o_state = STATE_SIZE'(r_state);

endmodule

// File: rtl/jtag_ahb_dap.sv
// JTAG debug access port: TAP, IR/DR shifters, CSR and single-master AHB-Lite.
module jtag_ahb_dap import jtag_ahb_dap_pkg::*; #(
  parameter int          REGISTER_SIZE = 32,
  parameter int          ADDR_SIZE     = 32,
  parameter int          IR_SIZE       = 4,
  parameter int          STATE_SIZE    = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0A5B
) (
  input  logic                     TCK,
  input  logic                     TRST_N,
  input  logic                     TMS,
  input  logic                     TDI,
  output logic                     TDO,
  input  logic                     HREADY,
  input  logic                     HRESP,
  input  logic [REGISTER_SIZE-1:0] HRDATA,
  output logic [ADDR_SIZE-1:0]     HADDR,
  output logic                     HWRITE,
  output logic [1:0]               HTRANS,
  output logic [2:0]               HSIZE,
  output logic [REGISTER_SIZE-1:0] HWDATA
);

  localparam int DR_W_AD = (ADDR_SIZE > REGISTER_SIZE) ? ADDR_SIZE : REGISTER_SIZE;
  localparam int DR_W    = (DR_W_AD > 32) ? DR_W_AD : 32;

  logic [STATE_SIZE-1:0]    w_state_bits;
  tap_state_t               w_state;
  logic [IR_SIZE-1:0]       r_ir, r_ir_sh;
  logic [DR_W-1:0]          r_dr_sh, w_dr_shift, w_dr_cap;
  dr_sel_t                  w_dr_sel;
  ahb_state_t               r_ahb, w_ahb_nxt;
  logic                     w_upd_dr, w_launch, w_busy, w_accept, w_drop, w_done, w_csr_upd;
  logic [ADDR_SIZE-1:0]     r_addr;
  logic [REGISTER_SIZE-1:0] r_wdata, r_hwdata, r_rdata;
  logic                     r_hwrite, r_autoinc, r_err, r_ovr, r_tdo;
  logic [2:0]               r_hsize;
  logic [7:0]               w_csr;

  jtag_tap_fsm #(.STATE_SIZE(STATE_SIZE)) u_tap (
    .TCK     (TCK),
    .TRST_N  (TRST_N),
    .TMS     (TMS),
    .o_state (w_state_bits)
  );

  assign w_state   = tap_state_t'(w_state_bits[3:0]);
  assign w_upd_dr  = (w_state == UPD_DR);
  assign w_busy    = (r_ahb != AHB_IDLE);
  assign w_launch  = w_upd_dr && ((w_dr_sel == DR_WDATA) || (w_dr_sel == DR_RDATA));
  assign w_accept  = w_launch && !w_busy;
  assign w_drop    = w_launch && w_busy;
  assign w_done    = (r_ahb == AHB_DATA) && HREADY;
  assign w_csr_upd = w_upd_dr && (w_dr_sel == DR_CSR);

  // Instruction decode; unrecognised codes fall through to BYPASS
  always_comb begin
    w_dr_sel = DR_BYPASS;
    case (r_ir)
      IR_SIZE'(IR_IDCODE): w_dr_sel = DR_IDCODE;
      IR_SIZE'(IR_ADDR):   w_dr_sel = DR_ADDR;
      IR_SIZE'(IR_WDATA):  w_dr_sel = DR_WDATA;
      IR_SIZE'(IR_RDATA):  w_dr_sel = DR_RDATA;
      IR_SIZE'(IR_CSR):    w_dr_sel = DR_CSR;
      default:             w_dr_sel = DR_BYPASS;
    endcase
  end

  // CSR view: busy is live, bit 7 reads zero
  always_comb begin
    w_csr                            = '0;
    w_csr[CSR_AUTOINC]               = r_autoinc;
    w_csr[CSR_HSIZE_HI:CSR_HSIZE_LO] = r_hsize;
    w_csr[CSR_ERR]                   = r_err;
    w_csr[CSR_OVR]                   = r_ovr;
    w_csr[CSR_BUSY]                  = w_busy;
  end

  // Capture value for the selected data register
  always_comb begin
    w_dr_cap = '0;
    case (w_dr_sel)
      DR_IDCODE: w_dr_cap = DR_W'(IDCODE_VALUE);
      DR_ADDR:   w_dr_cap = DR_W'(r_addr);
      DR_WDATA:  w_dr_cap = DR_W'(r_wdata);
      DR_RDATA:  w_dr_cap = DR_W'(r_rdata);
      DR_CSR:    w_dr_cap = DR_W'(w_csr);
      default:   w_dr_cap = '0;
    endcase
  end

  // Shift right; TDI enters at the MSB of the selected register's length
  always_comb begin
    w_dr_shift = r_dr_sh >> 1;
    case (w_dr_sel)
      DR_IDCODE:          w_dr_shift[31]              = TDI;
      DR_ADDR:            w_dr_shift[ADDR_SIZE-1]     = TDI;
      DR_WDATA, DR_RDATA: w_dr_shift[REGISTER_SIZE-1] = TDI;
      DR_CSR:             w_dr_shift[7]               = TDI;
      default:            w_dr_shift[0]               = TDI;
    endcase
  end

  // IR and DR shift chains (pure data path, no reset needed)
  always_ff @(posedge TCK) begin
    case (w_state)
      CAP_IR:  r_ir_sh <= IR_SIZE'(4'b0001);
      SH_IR:   r_ir_sh <= {TDI, r_ir_sh[IR_SIZE-1:1]};
      CAP_DR:  r_dr_sh <= w_dr_cap;
      SH_DR:   r_dr_sh <= w_dr_shift;
      default: ;
    endcase
  end

  // Instruction register: IDCODE in TLR, loaded on Update-IR
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N)                r_ir <= IR_SIZE'(IR_IDCODE);
    else if (w_state == TLR)    r_ir <= IR_SIZE'(IR_IDCODE);
    else if (w_state == UPD_IR) r_ir <= r_ir_sh;
  end

  // TDO changes on the falling edge so it is stable at the probe's sample
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N)               r_tdo <= 1'b0;
    else if (w_state == SH_DR) r_tdo <= r_dr_sh[0];
    else if (w_state == SH_IR) r_tdo <= r_ir_sh[0];
    else                       r_tdo <= 1'b0;
  end

  // AHB master state register
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) r_ahb <= AHB_IDLE;
    else         r_ahb <= w_ahb_nxt;
  end

  // AHB master next state: one address cycle, data phase until HREADY
  always_comb begin
    w_ahb_nxt = r_ahb;
    case (r_ahb)
      AHB_IDLE: if (w_accept) w_ahb_nxt = AHB_ADDR;
      AHB_ADDR: w_ahb_nxt = AHB_DATA;
      AHB_DATA: if (HREADY) w_ahb_nxt = AHB_IDLE;
      default:  w_ahb_nxt = AHB_IDLE;
    endcase
  end

  // Address, write/read data and direction; dropped launches touch nothing
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hwdata <= '0;
      r_hwrite <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_upd_dr && (w_dr_sel == DR_ADDR)) r_addr <= r_dr_sh[ADDR_SIZE-1:0];
      else if (w_done && r_autoinc)          r_addr <= r_addr + (ADDR_SIZE'(1) << r_hsize);
      if (w_accept) begin
        r_hwrite <= (w_dr_sel == DR_WDATA);
        if (w_dr_sel == DR_WDATA) r_wdata <= r_dr_sh[REGISTER_SIZE-1:0];
      end
      if ((r_ahb == AHB_ADDR) && r_hwrite) r_hwdata <= r_wdata;
      if (w_done && !r_hwrite)             r_rdata  <= HRDATA;
    end
  end

  // CSR fields; a same-cycle set beats a write-1-to-clear
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_autoinc <= 1'b0;
      r_hsize   <= HSIZE_WORD;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_csr_upd) begin
        r_autoinc <= r_dr_sh[CSR_AUTOINC];
        r_hsize   <= r_dr_sh[CSR_HSIZE_HI:CSR_HSIZE_LO];
      end
      if (w_done && HRESP)                  r_err <= 1'b1;
      else if (w_csr_upd && r_dr_sh[CSR_ERR]) r_err <= 1'b0;
      if (w_drop)                           r_ovr <= 1'b1;
      else if (w_csr_upd && r_dr_sh[CSR_OVR]) r_ovr <= 1'b0;
    end
  end

  assign TDO    = r_tdo;
  assign HADDR  = r_addr;
  assign HWRITE = r_hwrite;
  assign HTRANS = (r_ahb == AHB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE  = r_hsize;
  assign HWDATA = r_hwdata;

endmodule

// File: tb/tb_jtag_ahb_dap.sv
// Directed bench for jtag_ahb_dap: vector table plus hand-written AHB sequences.
module tb_jtag_ahb_dap;
  import jtag_ahb_dap_pkg::*;

  logic        TCK = 1'b0;
  logic        TRST_N, TMS, TDI, TDO;
  logic        HREADY, HRESP, HWRITE;
  logic [31:0] HRDATA, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  int n_vec = 0;
  int n_err = 0;
  int nonseq_cnt = 0;

  jtag_ahb_dap dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  always #5 TCK = ~TCK;

  // one count per address-phase cycle seen on the bus
  always @(negedge TCK) if (HTRANS == 2'b10) nonseq_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  ir;
    int          len;
    logic [63:0] din;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK);
    TMS = tms;
    TDI = tdi;
    #1 tdo = TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic t(input logic tms);
    logic d;
    tck(tms, 1'b0, d);
  endtask

  // RTI -> shift IR -> Update-IR -> RTI
  task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
    logic b;
    t(1); t(1); t(0); t(0);
    for (int i = 0; i < 4; i++) begin
      tck(i == 3, code[i], b);
      cap[i] = b;
    end
    t(1); t(0);
  endtask

  // RTI -> shift DR -> Update-DR -> RTI; the last edge is the launch edge
  task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    t(1); t(0); t(0);
    for (int i = 0; i < len; i++) begin
      tck(i == len - 1, din[i], b);
      dout[i] = b;
    end
    t(1); t(0);
  endtask

  initial begin
    logic [63:0] d;
    logic [3:0]  irc;
    int          n0;

    vecs[0] = '{IR_IDCODE, 32, 64'h0,        64'h1000_0A5B, "idcode"};
    vecs[1] = '{IR_BYPASS, 9,  64'h0A5,      64'h14A,       "bypass_a5"};
    vecs[2] = '{4'hF,      9,  64'h0A5,      64'h14A,       "bypass_code_f"};
    vecs[3] = '{4'h6,      9,  64'h1FF,      64'h1FE,       "bypass_code_6"};
    vecs[4] = '{IR_ADDR,   32, 64'h12345678, 64'h0,         "addr_capture_reset"};
    vecs[5] = '{IR_ADDR,   32, 64'h100,      64'h12345678,  "addr_roundtrip"};
    vecs[6] = '{IR_CSR,    8,  64'h05,       64'h04,        "csr_reset_value"};
    vecs[7] = '{IR_CSR,    8,  64'h05,       64'h05,        "csr_readback"};

    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    // reset values
    #12;
    check("rst_tdo", TDO, 0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_hsize", HSIZE, 3'b010);
    TRST_N = 1'b1;
    t(0);
    shift_dr(32, 64'h0, d);
    check("idcode_after_reset", d, 64'h1000_0A5B);

    // five TMS=1 from Shift-DR reach TLR and reload IDCODE
    shift_ir(IR_BYPASS, irc);
    t(1); t(0); t(0);
    for (int i = 0; i < 5; i++) t(1);
    t(0);
    shift_dr(32, 64'h0, d);
    check("tlr_reloads_idcode", d, 64'h1000_0A5B);

    // vector table; leaves CSR=8'h05 and ADDR=0x100
    for (int i = 0; i < 8; i++) begin
      shift_ir(vecs[i].ir, irc);
      check("ir_capture", irc, 4'b0001);
      shift_dr(vecs[i].len, vecs[i].din, d);
      check(vecs[i].name, d & ((64'd1 << vecs[i].len) - 1), vecs[i].exp);
    end

    // write with auto-increment
    n0 = nonseq_cnt;
    shift_ir(IR_WDATA, irc);
    shift_dr(32, 64'h89ABCDEF, d);
    check("wr1_htrans", HTRANS, 2'b10);
    check("wr1_hwrite", HWRITE, 1);
    check("wr1_haddr", HADDR, 32'h100);
    @(posedge TCK); #1;
    check("wr1_dphase_htrans", HTRANS, 2'b00);
    check("wr1_hwdata", HWDATA, 32'h89ABCDEF);
    @(posedge TCK); #1;
    shift_dr(32, 64'h1, d);
    check("wr2_htrans", HTRANS, 2'b10);
    check("wr2_haddr", HADDR, 32'h104);
    @(posedge TCK); #1;
    check("wr2_hwdata", HWDATA, 32'h1);
    @(posedge TCK); #1;
    check("wr_nonseq_count", nonseq_cnt - n0, 2);
    shift_ir(IR_ADDR, irc);
    shift_dr(32, 64'h108, d);
    check("wr_final_addr", d, 32'h108);

    // autoinc off, hsize kept
    shift_ir(IR_CSR, irc);
    shift_dr(8, 64'h04, d);
    check("csr_before_read", d, 8'h05);

    // read with three wait states; HRDATA is only F00F on the expected completion edge
    shift_ir(IR_RDATA, irc);
    HRDATA = 32'h0000_DEAD;
    shift_dr(32, 64'h0, d);
    check("rd_htrans", HTRANS, 2'b10);
    check("rd_hwrite", HWRITE, 0);
    check("rd_haddr", HADDR, 32'h108);
    HREADY = 1'b0;
    @(posedge TCK); #1;
    check("rd_dphase_htrans", HTRANS, 2'b00);
    @(posedge TCK); #1;
    @(posedge TCK); #1;
    @(posedge TCK); #1;
    HREADY = 1'b1; HRDATA = 32'h0000_F00F;
    @(posedge TCK); #1;
    HRDATA = 32'h0000_BAD1;
    shift_dr(32, 64'h0, d);
    check("rd_data_capture", d, 32'h0000_F00F);
    @(posedge TCK); #1;
    @(posedge TCK); #1;

    // error and overrun
    HREADY = 1'b0;
    n0 = nonseq_cnt;
    shift_dr(32, 64'h0, d);
    check("err_launch_htrans", HTRANS, 2'b10);
    shift_dr(32, 64'h0, d);
    check("ovr_dropped_htrans", HTRANS, 2'b00);
    shift_ir(IR_CSR, irc);
    shift_dr(8, 64'h04, d);
    check("csr_busy_ovr", d, 8'h64);
    HRESP = 1'b1; HREADY = 1'b1;
    @(posedge TCK); #1;
    HRESP = 1'b0;
    check("ovr_single_nonseq", nonseq_cnt - n0, 1);
    shift_dr(8, 64'h04, d);
    check("csr_err_ovr", d, 8'h34);
    shift_dr(8, 64'h34, d);
    check("csr_before_w1c", d, 8'h34);
    shift_dr(8, 64'h04, d);
    check("csr_after_w1c", d, 8'h04);

    // asynchronous reset during a data phase
    shift_dr(8, 64'h07, d);
    check("hsize_from_csr", HSIZE, 3'b011);
    shift_ir(IR_RDATA, irc);
    HREADY = 1'b0;
    shift_dr(32, 64'h0, d);
    check("mid_launch_htrans", HTRANS, 2'b10);
    @(posedge TCK); #1;
    #2 TRST_N = 1'b0;
    #1;
    check("mid_rst_htrans", HTRANS, 2'b00);
    check("mid_rst_hsize", HSIZE, 3'b010);
    check("mid_rst_haddr", HADDR, 0);
    check("mid_rst_hwrite", HWRITE, 0);
    #20 TRST_N = 1'b1;
    HREADY = 1'b1;
    t(0);
    shift_ir(IR_CSR, irc);
    shift_dr(8, 64'h04, d);
    check("mid_rst_csr", d, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
